sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO: the next generation of the team's 8-bit synchronous FIFO, generalised in data width and depth. It adds:
- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags with a clear input.

It sits between a producer and a consumer in the same clock domain. Rejected accesses are reported, never silently corrupting storage.

## Interface
Parameters:
- DATA_WIDTH, 8, width of write_data/read_data
- DEPTH, 16, number of entries; power of two, >= 2
- AF_TH, DEPTH-2, almost_full asserts when count >= AF_TH (1..DEPTH)
- AE_TH, 2, almost_empty asserts when count <= AE_TH (0..DEPTH-1)

Ports (AW = $clog2(DEPTH)):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- read  in  1  read request, sampled at posedge clk
- write  in  1  write request, sampled at posedge clk
- write_data  in  DATA_WIDTH  data stored on accepted write
- clear_err  in  1  synchronous clear of overflow/underflow
- read_data  out  DATA_WIDTH  registered output of last accepted read
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_TH
- almost_empty  out  1  count <= AE_TH
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty

## Operation
Reset values, applied asynchronously on reset:
- pointers = 0, count = 0, read_data = 0;
- empty = 1, full = 0, almost_empty = 1, almost_full = 0 (for AF_TH >= 1);
- overflow = 0, underflow = 0.

Storage contents are not reset.

Pointers:
- wr_ptr and rd_ptr are AW bits.
- Each increments by 1 on an accepted access and wraps DEPTH-1 -> 0 naturally.
- count is held separately and tracks occupancy.

Read acceptance:
- rd_ok = read & ~empty.

Write acceptance:
- wr_ok = write & (~full | rd_ok).
- A write to a full FIFO is accepted only when a read is accepted in the same cycle.

Accepted accesses:
- Accepted write: mem[wr_ptr] <= write_data.
- Accepted read: read_data <= mem[rd_ptr].
- read_data holds its value in every cycle without an accepted read.

count update:
- +1 on wr_ok only.
- -1 on rd_ok only.
- Unchanged on both or neither.

Simultaneous events:
- **Empty, read+write:** the write is accepted and the read is rejected. count 0->1, underflow sets.
- **Full, read+write:** both are accepted. count stays DEPTH and the oldest word is read out.
- **Partially filled, read+write:** both are accepted and count is unchanged.

Error flags:
- overflow sets on write & ~wr_ok.
- underflow sets on read & empty.
- Both hold until clear_err or reset.
- If clear_err and a new error occur in the same cycle, set wins.

All status outputs (full, empty, almost_*) are combinational decodes of the registered count.

## Timing
Latency:
- Write-to-read latency is 1 cycle: a word written at edge N is readable at edge N+1.
- read_data is valid after the edge that accepted the read; there is no first-word-fall-through.

Flag updates:
- count and all status flags update on the same edge as the access that changes them.
- overflow and underflow are visible the cycle after the offending request.

Reset mid-operation:
- Outputs go to their reset values immediately, without waiting for clk.
- The FIFO is empty after reset deasserts.
- The first edge after deassert may accept a write.

## Test plan
Run with DATA_WIDTH=8, DEPTH=4, AF_TH=3, AE_TH=1.
1. **Reset then fill and drain.** Stimulus: reset, write 0x11,0x22,0x33,0x44, then 4 reads. Required response: count goes 1,2,3,4; full=1 after the 4th write; read_data = 0x11,0x22,0x33,0x44 in order; empty=1 at the end; no error flags.
2. **Overflow.** Stimulus: with the FIFO full, write 0x55 alone. Required response: count stays 4, overflow=1, and a subsequent drain returns 0x11..0x44 with no 0x55. Then pulse clear_err: overflow=0.
3. **Underflow and empty read+write.** Stimulus: on an empty FIFO, read alone. Required response: underflow=1, read_data unchanged. Then read+write 0xAA together: count=1, and the next read returns 0xAA.
4. **Full read+write.** Stimulus: full with 0x11..0x44, read+write 0x99. Required response: read_data=0x11, count=4, no overflow. Draining then returns 0x22,0x33,0x44,0x99.
5. **Wrap and thresholds.** Stimulus: run 10 cycles of alternating writes/reads so both pointers wrap. Required response: data order is preserved; almost_empty=1 when count <= 1; almost_full=1 exactly when count >= 3.
6. **Async reset mid-burst.** Stimulus: assert reset between edges with count=3. Required response: count=0, empty=1, read_data=0 before the next posedge.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_TH      = DEPTH - 2,
    parameter int AE_TH      = 2,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_TH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_TH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  w_rd_ok;
    logic                  w_wr_ok;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign w_rd_ok = read & ~empty;
    assign w_wr_ok = write & (~full | w_rd_ok);

    assign count        = r_count;
    assign full         = (r_count == DEPTH_C);
    assign empty        = (r_count == (AW+1)'(0));
    assign almost_full  = (r_count >= AF_C);
    assign almost_empty = (r_count <= AE_C);

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

    // Pointers, occupancy and read data register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            read_data <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                read_data <= r_mem[r_rd_ptr];
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle beats clear_err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write & ~w_wr_ok) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (read & empty) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param with DEPTH=4, AF_TH=3, AE_TH=1.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [7:0] write_data = 8'h00;
    logic       clear_err = 1'b0;
    logic [7:0] read_data;
    logic       full, empty, almost_full, almost_empty;
    logic [2:0] count;
    logic       overflow, underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(4), .AF_TH(3), .AE_TH(1)) dut (
        .clk(clk), .reset(reset), .read(read), .write(write),
        .write_data(write_data), .clear_err(clear_err), .read_data(read_data),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, return 1 time unit after the rising edge.
    task automatic cyc(input logic rd, input logic wr, input logic [7:0] d, input logic clr);
        @(negedge clk);
        read = rd; write = wr; write_data = d; clear_err = clr;
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0; clear_err = 1'b0;
    endtask

    task automatic fill4();
        cyc(1'b0, 1'b1, 8'h11, 1'b0);
        cyc(1'b0, 1'b1, 8'h22, 1'b0);
        cyc(1'b0, 1'b1, 8'h33, 1'b0);
        cyc(1'b0, 1'b1, 8'h44, 1'b0);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({count, empty, full, almost_empty, almost_full, overflow, underflow} !== 9'b000_1010_00 ||
            read_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b rd=%h exp 0 1 0 1 0 0 0 00",
                     count, empty, full, almost_empty, almost_full, overflow, underflow, read_data);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [7:0] dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic       af_exp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       ae_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, dat[i], 1'b0);
            checks++;
            if (count !== 3'(i + 1) || full !== (i == 3) || almost_full !== af_exp[i] ||
                almost_empty !== ae_exp[i]) begin
                errors++;
                $display("FAIL fill_%0d got cnt=%0d f=%b af=%b ae=%b exp cnt=%0d f=%b af=%b ae=%b",
                         i, count, full, almost_full, almost_empty, i + 1, (i == 3), af_exp[i], ae_exp[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0);
            checks++;
            if (read_data !== dat[i] || count !== 3'(3 - i)) begin
                errors++;
                $display("FAIL drain_%0d got rd=%h cnt=%0d exp rd=%h cnt=%0d", i, read_data, count, dat[i], 3 - i);
            end
        end
        checks++;
        if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_drain_end got e=%b ov=%b un=%b exp 1 0 0", empty, overflow, underflow);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        fill4();
        cyc(1'b0, 1'b1, 8'h55, 1'b0);
        checks++;
        if (count !== 3'd4 || overflow !== 1'b1 || full !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set got cnt=%0d ov=%b f=%b exp 4 1 1", count, overflow, full);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0);
            checks++;
            if (read_data !== dat[i]) begin
                errors++;
                $display("FAIL overflow_drain_%0d got %h exp %h", i, read_data, dat[i]);
            end
        end
        checks++;
        if (overflow !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky got ov=%b e=%b exp 1 1", overflow, empty);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got %b exp 0", overflow);
        end
    endtask

    task automatic test_underflow();
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (underflow !== 1'b1 || read_data !== 8'h44 || count !== 3'd0) begin
            errors++;
            $display("FAIL underflow_set got un=%b rd=%h cnt=%0d exp 1 44 0", underflow, read_data, count);
        end
        cyc(1'b1, 1'b1, 8'hAA, 1'b0);
        checks++;
        if (count !== 3'd1 || read_data !== 8'h44 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL empty_rw got cnt=%0d rd=%h un=%b exp 1 44 1", count, read_data, underflow);
        end
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (read_data !== 8'hAA || count !== 3'd0) begin
            errors++;
            $display("FAIL empty_rw_read got rd=%h cnt=%0d exp AA 0", read_data, count);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear got %b exp 0", underflow);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] dat [4] = '{8'h22, 8'h33, 8'h44, 8'h99};
        fill4();
        cyc(1'b1, 1'b1, 8'h99, 1'b0);
        checks++;
        if (read_data !== 8'h11 || count !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_rw got rd=%h cnt=%0d ov=%b f=%b exp 11 4 0 1", read_data, count, overflow, full);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0);
            checks++;
            if (read_data !== dat[i]) begin
                errors++;
                $display("FAIL full_rw_drain_%0d got %h exp %h", i, read_data, dat[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] rexp [5] = '{8'h01, 8'h02, 8'h60, 8'h61, 8'h62};
        logic [7:0] dexp [3] = '{8'h63, 8'h64, 8'h00};
        cyc(1'b0, 1'b1, 8'h01, 1'b0);
        cyc(1'b0, 1'b1, 8'h02, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
            checks++;
            if (count !== 3'd3 || almost_full !== 1'b1 || almost_empty !== 1'b0) begin
                errors++;
                $display("FAIL wrap_w%0d got cnt=%0d af=%b ae=%b exp 3 1 0", i, count, almost_full, almost_empty);
            end
            cyc(1'b1, 1'b0, 8'h00, 1'b0);
            checks++;
            if (read_data !== rexp[i] || count !== 3'd2 || almost_full !== 1'b0 || almost_empty !== 1'b0) begin
                errors++;
                $display("FAIL wrap_r%0d got rd=%h cnt=%0d af=%b ae=%b exp %h 2 0 0",
                         i, read_data, count, almost_full, almost_empty, rexp[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0);
            checks++;
            if (read_data !== dexp[i] || count !== 3'(1 - i) || almost_empty !== 1'b1) begin
                errors++;
                $display("FAIL wrap_drain_%0d got rd=%h cnt=%0d ae=%b exp %h %0d 1",
                         i, read_data, count, almost_empty, dexp[i], 1 - i);
            end
        end
    endtask

    task automatic test_async_reset();
        cyc(1'b0, 1'b1, 8'h31, 1'b0);
        cyc(1'b0, 1'b1, 8'h32, 1'b0);
        cyc(1'b0, 1'b1, 8'h33, 1'b0);
        checks++;
        if (count !== 3'd3 || read_data !== 8'h64) begin
            errors++;
            $display("FAIL pre_reset got cnt=%0d rd=%h exp 3 64", count, read_data);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || read_data !== 8'h00 || full !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d e=%b rd=%h f=%b exp 0 1 00 0", count, empty, read_data, full);
        end
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 8'h77, 1'b0);
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL post_reset_write got cnt=%0d exp 1", count);
        end
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (read_data !== 8'h77 || empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_read got rd=%h e=%b exp 77 1", read_data, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_full_rw();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
